// File: rtl/hp_bar_animator.sv
// Animates an HP bar: each damage/heal request redraws the changed columns one
// pixel per cycle, then pulses done; game_over latches once HP reaches zero.
module hp_bar_animator #(
    parameter int unsigned MAX_HP   = 75,
    parameter int unsigned HP_W     = 9,
    parameter int unsigned BAR_X0   = 222,
    parameter int unsigned BAR_Y    = 119,
    parameter int unsigned BAR_H    = 3,
    parameter int unsigned X_W      = 9,
    parameter int unsigned Y_W      = 8,
    parameter logic [2:0]  COL_DMG  = 3'b111,
    parameter logic [2:0]  COL_HEAL = 3'b010
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_heal,
    input  logic [HP_W-1:0] req_amount,
    output logic            req_ready,
    output logic [HP_W-1:0] hp,
    output logic [X_W-1:0]  out_x,
    output logic [Y_W-1:0]  out_y,
    output logic [2:0]      out_colour,
    output logic            plot,
    output logic            done,
    output logic            game_over
);

    localparam int unsigned SUM_W = HP_W + 1;
    localparam int unsigned ROW_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;

    localparam logic [SUM_W-1:0] MAX_HP_S = SUM_W'(MAX_HP);
    localparam logic [HP_W-1:0]  MAX_HP_H = HP_W'(MAX_HP);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BAR_H - 1);
    localparam logic [X_W-1:0]   X0       = X_W'(BAR_X0);
    localparam logic [Y_W-1:0]   Y0       = Y_W'(BAR_Y);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DRAW,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic            heal;
        logic [HP_W-1:0] amount;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [HP_W-1:0]   target_q, target_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic              plot_q, plot_d;
    logic [X_W-1:0]    out_x_q, out_x_d;
    logic [Y_W-1:0]    out_y_q, out_y_d;
    logic [2:0]        out_colour_q, out_colour_d;
    logic              done_q, done_d;
    logic              game_over_q, game_over_d;
    logic              req_ready_q, req_ready_d;

    logic [SUM_W-1:0]  heal_sum;
    logic [HP_W-1:0]   dmg_diff;

    // Next-state logic; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        hp_d      = hp_q;
        target_d  = target_q;
        row_d     = row_q;
        heal_sum  = {1'b0, hp_q} + {1'b0, req_q.amount};
        dmg_diff  = hp_q - req_q.amount;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.heal   = req_heal;
                    req_d.amount = req_amount;
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                if (req_q.heal) begin
                    target_d = (heal_sum > MAX_HP_S) ? MAX_HP_H : heal_sum[HP_W-1:0];
                end else begin
                    target_d = (req_q.amount > hp_q) ? '0 : dmg_diff;
                end
                row_d   = '0;
                state_d = (target_d != hp_q) ? ST_DRAW : ST_DONE;
            end
            ST_DRAW: begin
                if (row_q == LAST_ROW) begin
                    row_d = '0;
                    hp_d  = req_q.heal ? (hp_q + HP_W'(1)) : (hp_q - HP_W'(1));
                    if (hp_d == target_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_DONE: begin
                req_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A damage column sits left of the current HP edge, a heal column right of it
        plot_d       = (state_d == ST_DRAW);
        out_x_d      = req_d.heal ? (X0 + X_W'(hp_d)) : (X0 + X_W'(hp_d) - X_W'(1));
        out_y_d      = Y0 + Y_W'(row_d);
        out_colour_d = req_d.heal ? COL_HEAL : COL_DMG;
        done_d       = (state_d == ST_DONE);
        game_over_d  = game_over_q | ((state_d == ST_DONE) && (hp_d == '0));
        req_ready_d  = (state_d == ST_IDLE) && !game_over_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            hp_q         <= MAX_HP_H;
            target_q     <= '0;
            row_q        <= '0;
            plot_q       <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            done_q       <= 1'b0;
            game_over_q  <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            hp_q         <= hp_d;
            target_q     <= target_d;
            row_q        <= row_d;
            plot_q       <= plot_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
            done_q       <= done_d;
            game_over_q  <= game_over_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign hp         = hp_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign plot       = plot_q;
    assign done       = done_q;
    assign game_over  = game_over_q;

endmodule
